// File: rtl/serial_parallel.sv
// serial_parallel: bit-serial receiver for the ABruTECH bus link.
// Waits for a one-cycle low start bit on din, shifts in bit_lngt data bits
// LSB first and presents the word on dout with a one-cycle dv_out strobe.
// Build option SERIAL_PARALLEL_STOP_CHECK_EN adds a stop-bit check: the
// word is delivered one edge later, and only if the line has returned to
// idle; a low stop sample raises frame_err instead.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a low start sample; latches bit_lngt on start
// RECEIVE | shifting in data bits, one per edge, LSB first
// STOP    | (stop check only) sampling the stop bit after the last bit
module serial_parallel #(
    parameter int PARALLEL_PORT_WIDTH = 14,
    parameter int BIT_LENGTH          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           din,
    input  logic [BIT_LENGTH-1:0]          bit_lngt,
    output logic [PARALLEL_PORT_WIDTH-1:0] dout,
    output logic                           dv_out,
    output logic                           busy,
    output logic                           frame_err
);

    localparam int W = PARALLEL_PORT_WIDTH;

`ifdef SERIAL_PARALLEL_STOP_CHECK_EN
    typedef enum logic [1:0] {IDLE, RECEIVE, STOP} state_t;
`else
    typedef enum logic [0:0] {IDLE, RECEIVE} state_t;
`endif

    state_t                state_q;
    logic [W-1:0]          buf_q;
    logic [W-1:0]          buf_d;
    logic [W-1:0]          dout_q;
    logic [BIT_LENGTH-1:0] cnt_q;
    logic [BIT_LENGTH-1:0] len_q;
    logic [BIT_LENGTH-1:0] last_cnt;
    logic                  dv_q;
    logic                  busy_q;
    logic                  din_low;
    logic                  bit_val;
    logic                  last_bit;

    // Only a solid logic 0 counts as low; 1, Z and X all read as idle / data 1.
    always_comb begin
        din_low = 1'b0;
        if (din == 1'b0) begin
            din_low = 1'b1;
        end
        bit_val = ~din_low;
    end

    // The buffer is cleared at start, so OR-ing in the new bit is enough;
    // bits at positions beyond the port width shift out and are dropped.
    always_comb begin
        buf_d = buf_q | (W'(bit_val) << cnt_q);
    end

    // Last-bit compare wraps modulo 2^BIT_LENGTH, so len_q == 0 gives a full-range frame.
    assign last_cnt = len_q - 1'b1;
    assign last_bit = (cnt_q == last_cnt);

`ifdef SERIAL_PARALLEL_STOP_CHECK_EN
    logic fe_q;
    logic wait_idle_q;

    // Receiver FSM with stop-bit check; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            dout_q      <= '0;
            dv_q        <= 1'b0;
            busy_q      <= 1'b0;
            fe_q        <= 1'b0;
            wait_idle_q <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            fe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wait_idle_q) begin
                        // After a framing error the line must be seen idle before a new start.
                        if (!din_low) begin
                            wait_idle_q <= 1'b0;
                        end
                    end else if (din_low) begin
                        state_q <= RECEIVE;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        len_q   <= bit_lngt;
                        busy_q  <= 1'b1;
                    end
                end
                RECEIVE: begin
                    buf_q <= buf_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (din_low) begin
                        fe_q        <= 1'b1;
                        wait_idle_q <= 1'b1;
                    end else begin
                        dout_q <= buf_q;
                        dv_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_err = fe_q;
`else
    // Receiver FSM without stop check; word delivered on the last-bit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (din_low) begin
                        state_q <= RECEIVE;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        len_q   <= bit_lngt;
                        busy_q  <= 1'b1;
                    end
                end
                RECEIVE: begin
                    buf_q <= buf_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        dout_q  <= buf_d;
                        dv_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_err = 1'b0;
`endif

    assign dout   = dout_q;
    assign dv_out = dv_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_serial_parallel.sv
// Testbench for serial_parallel: table of frames plus hand-written
// sequences for idle-Z, mid-frame reset, bit_lngt change and stop check.
module tb_serial_parallel;

    logic        clk;
    logic        rst;
    logic        drv_en;
    logic        din_drv;
    logic [3:0]  bit_lngt;
    logic [13:0] dout;
    logic        dv_out;
    logic        busy;
    logic        frame_err;
    tri1         din_w;

    int checks;
    int errors;
    int dv_cnt;
    int fe_cnt;
    int exp_dv;
    int exp_fe;
    logic dv_prev;
    logic fe_prev;

    assign din_w = drv_en ? din_drv : 1'bz;

    serial_parallel #(
        .PARALLEL_PORT_WIDTH(14),
        .BIT_LENGTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din_w),
        .bit_lngt(bit_lngt),
        .dout(dout),
        .dv_out(dv_out),
        .busy(busy),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  len;
        logic [15:0] data;
        int          gap;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start bit then n data bits LSB first; returns just after the last-bit edge.
    task automatic send_bits(input int n, input logic [15:0] data);
        din_drv = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            din_drv = data[i];
            tick();
        end
    endtask

    // With the stop check the word appears one edge later, after an idle stop sample.
    task automatic finish_frame();
`ifdef SERIAL_PARALLEL_STOP_CHECK_EN
        din_drv = 1'b1;
        tick();
`endif
    endtask

    // Strobe-shape monitor: pulses one cycle wide, never together; counts strobes.
    initial begin
        dv_prev = 1'b0;
        fe_prev = 1'b0;
        dv_cnt  = 0;
        fe_cnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if ((dv_out && frame_err) || (dv_out && dv_prev) || (frame_err && fe_prev)) begin
                    errors++;
                    $display("FAIL strobe_shape: dv_out=%0b frame_err=%0b prev_dv=%0b prev_fe=%0b, expected exclusive single-cycle pulses",
                             dv_out, frame_err, dv_prev, fe_prev);
                end
                if (dv_out) dv_cnt++;
                if (frame_err) fe_cnt++;
            end
            dv_prev = dv_out && !rst;
            fe_prev = frame_err && !rst;
        end
    end

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        exp_dv   = 0;
        exp_fe   = 0;
        rst      = 1'b1;
        drv_en   = 1'b1;
        din_drv  = 1'b1;
        bit_lngt = 4'd8;

        vecs[0]  = '{4'd8,  16'h00A5, 2, 14'h00A5};
        vecs[1]  = '{4'd14, 16'h3FFF, 1, 14'h3FFF};
        vecs[2]  = '{4'd14, 16'h0001, 3, 14'h0001};
        vecs[3]  = '{4'd4,  16'h000B, 1, 14'h000B};
        vecs[4]  = '{4'd1,  16'h0001, 0, 14'h0001};
        vecs[5]  = '{4'd1,  16'h0000, 1, 14'h0000};
        vecs[6]  = '{4'd15, 16'h7FFF, 1, 14'h3FFF};
        vecs[7]  = '{4'd3,  16'h0005, 1, 14'h0005};
        vecs[8]  = '{4'd8,  16'h0000, 1, 14'h0000};
        vecs[9]  = '{4'd0,  16'hFFFF, 1, 14'h3FFF};
        vecs[10] = '{4'd0,  16'hE5A6, 1, 14'h25A6};

        repeat (3) tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dv", 32'(dv_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        rst = 1'b0;

        // Released (pulled-up, Z-driven) line must never look like a start.
        drv_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("z%0d_busy", c), 32'(busy), 32'h0);
            chk($sformatf("z%0d_dv", c), 32'(dv_out), 32'h0);
            chk($sformatf("z%0d_dout", c), 32'(dout), 32'h0);
        end
        drv_en  = 1'b1;
        din_drv = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            bit_lngt = vecs[i].len;
            n = (vecs[i].len == 4'd0) ? 16 : int'(vecs[i].len);
            send_bits(n, vecs[i].data);
            finish_frame();
            exp_dv++;
            chk($sformatf("v%0d_dv", i), 32'(dv_out), 32'h1);
            chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].exp));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_fe", i), 32'(frame_err), 32'h0);
            if (vecs[i].gap > 0) begin
                din_drv = 1'b1;
                tick();
                chk($sformatf("v%0d_dv_drop", i), 32'(dv_out), 32'h0);
                repeat (vecs[i].gap - 1) tick();
            end
        end

        // Reset three bits into an 8-bit 0xFF frame.
        bit_lngt = 4'd8;
        send_bits(3, 16'h00FF);
        chk("mid_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_dout", 32'(dout), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_dv", 32'(dv_out), 32'h0);
        din_drv = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        send_bits(8, 16'h0012);
        finish_frame();
        exp_dv++;
        chk("post_rst_dv", 32'(dv_out), 32'h1);
        chk("post_rst_dout", 32'(dout), 32'h0012);
        din_drv = 1'b1;
        tick();

        // bit_lngt drops from 8 to 3 after the start: the frame stays 8 bits.
        bit_lngt = 4'd8;
        din_drv  = 1'b0;
        tick();
        bit_lngt = 4'd3;
        for (int i = 0; i < 8; i++) begin
            din_drv = (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0;
            tick();
            if (i == 2) chk("len_chg_no_early_dv", 32'(dv_out), 32'h0);
        end
        finish_frame();
        exp_dv++;
        chk("len_chg_dv", 32'(dv_out), 32'h1);
        chk("len_chg_dout", 32'(dout), 32'h00C3);
        din_drv = 1'b1;
        tick();

`ifdef SERIAL_PARALLEL_STOP_CHECK_EN
        // Bits 1,0,1,1 with a low stop sample: error, dout unchanged.
        bit_lngt = 4'd4;
        send_bits(4, 16'h000D);
        chk("stop_pending_busy", 32'(busy), 32'h1);
        din_drv = 1'b0;
        tick();
        exp_fe++;
        chk("stop_err_fe", 32'(frame_err), 32'h1);
        chk("stop_err_dv", 32'(dv_out), 32'h0);
        chk("stop_err_dout", 32'(dout), 32'h00C3);
        chk("stop_err_busy", 32'(busy), 32'h0);
        tick();
        chk("stop_low_no_start", 32'(busy), 32'h0);
        chk("stop_fe_drop", 32'(frame_err), 32'h0);
        din_drv = 1'b1;
        tick();
        chk("stop_idle_busy", 32'(busy), 32'h0);
        send_bits(4, 16'h000D);
        finish_frame();
        exp_dv++;
        chk("stop_ok_dv", 32'(dv_out), 32'h1);
        chk("stop_ok_dout", 32'(dout), 32'h000D);
        chk("stop_ok_fe", 32'(frame_err), 32'h0);
        din_drv = 1'b1;
        tick();
`endif

        tick();
        chk("dv_pulse_count", 32'(dv_cnt), 32'(exp_dv));
        chk("fe_pulse_count", 32'(fe_cnt), 32'(exp_fe));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parallel.md
# serial_parallel

Serial-to-parallel receiver for the ABruTECH bus bit-serial link. It watches a single serial line and detects the one-cycle low start bit. It then shifts in a programmable number of data bits, LSB first, and presents the assembled word on a parallel port with a one-cycle data-valid strobe. It sits at the receiving end of each serial bus line, driven by the parallel-to-serial transmitter in the same clock domain.

## Interface
- `PARALLEL_PORT_WIDTH`, default 14: width of the assembled parallel word.
- `BIT_LENGTH`, default 4: width of the bit-count input and of the internal bit counter.

- `clk` input 1: system clock; all sampling on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `din` input 1: serial line. Idle is any value other than logic 0 (1, Z or X); the start bit is logic 0.
- `bit_lngt` input `BIT_LENGTH`: number of data bits per frame; sampled when the start bit is detected.
- `dout` output `PARALLEL_PORT_WIDTH`: last received word, zero-extended above the frame length.
- `dv_out` output 1: one-cycle strobe; `dout` is valid in the same cycle.
- `busy` output 1: high while a frame is being received.
- `frame_err` output 1: one-cycle strobe on a stop-check failure; tied 0 unless the stop check is compiled in.

## Operation
- States: IDLE, RECEIVE, STOP. STOP exists only when the stop check is compiled in.
- IDLE
  - On a rising edge with `din == 0`: go to RECEIVE.
  - Clear the shift buffer and bit counter.
  - Latch `bit_lngt` into `len_q`.
- RECEIVE, one bit per edge
  - Store `buffer[cnt] <= din` only when `cnt < PARALLEL_PORT_WIDTH`; otherwise drop the bit.
  - Increment `cnt`.
  - Sampled non-0 values store 1.
- Last bit is the edge where `cnt == len_q - 1`, computed modulo 2^`BIT_LENGTH`.
  - `len_q == 0` therefore yields a 2^`BIT_LENGTH`-bit frame.
  - On that edge, without the stop check: load `dout` with the buffer including the last bit, pulse `dv_out`, return to IDLE.
  - With the stop check: go to STOP instead.
- `dout` holds its value between frames; bits at positions ≥ `len_q` are 0.
- `busy` is high in RECEIVE and STOP.
- A low `din` while in RECEIVE is data, never a new start.
- `bit_lngt` changes after start detection do not affect the current frame.

## Timing
- Reset values: `dout` = 0, `dv_out` = 0, `busy` = 0, `frame_err` = 0, state IDLE.
- Start detected at edge S; data bit i is sampled at edge S+1+i.
- Without the stop check: `dv_out` is high for the cycle following edge S+`len_q`.
  - A new start can be detected at edge S+`len_q`+1.
  - This is compatible with the transmitter, which always returns the line to idle for at least one cycle.
- With the stop check: `dv_out` or `frame_err` is high for the cycle following edge S+`len_q`+1.
  - The next start is accepted from edge S+`len_q`+2.
- `dv_out` and `frame_err` are never high together, and never longer than one cycle.
- Reset asserted mid-frame:
  - Aborts immediately, with no `dv_out` and no `frame_err`.
  - `dout` clears to 0.
  - After release, the first low sample is treated as a start.

## Configuration
- `SERIAL_PARALLEL_STOP_CHECK_EN`
  - Defined: STOP state samples `din` one edge after the last bit.
    - Idle (non-0): load `dout` and pulse `dv_out`.
    - 0: pulse `frame_err`, leave `dout` unchanged, return to IDLE.
    - A line still low after an error is not taken as a new start until it has been seen idle for one edge.
  - Undefined: no STOP state, `frame_err` tied 0, word delivered on the last-bit edge.

## Test plan
- `bit_lngt`=8, transmitter sends 0xA5 → `dout`=0x00A5, `dv_out` high exactly one cycle, `busy` low in the same cycle.
- `bit_lngt`=14, send 0x3FFF, then 0x0001 back-to-back with the minimum transmitter gap → two strobes, `dout` 0x3FFF then 0x0001, no missed start.
- Idle line held at Z for 20 cycles → no `busy`, no `dv_out`, `dout` stays 0.
- `rst` pulsed after 3 of 8 bits of 0xFF → `dout`=0, no strobe; a following frame 0x12 is received correctly.
- Stop check compiled in, `bit_lngt`=4, bits 1011 then `din`=0 in the stop cycle → `frame_err` pulse, `dout` keeps its prior value; the same frame with an idle stop → `dout`=0x000D.
- `bit_lngt` changed from 8 to 3 mid-frame → a full 8-bit word is delivered.
